apb_master: RTL and testbench
=============================

APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, APB address width.
REQ-002 The block SHALL have parameter DATA_W, default 8, APB data width.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 16, ACCESS-phase wait limit; used only when APB_MASTER_TIMEOUT_EN is defined.
REQ-004 pclk  in  1  sole clock; all logic on rising edge.
REQ-005 presetn  in  1  reset; synchronous and active-low.
REQ-006 cmd_valid  in  1  requester presents a transfer.
REQ-007 cmd_ready  out  1  block can accept a transfer.
REQ-008 cmd_write  in  1  1 = write, 0 = read.
REQ-009 cmd_addr  in  ADDR_W  transfer address.
REQ-010 cmd_wdata  in  DATA_W  write data.
REQ-011 rsp_valid  out  1  one-cycle completion pulse.
REQ-012 rsp_rdata  out  DATA_W  read data, valid with rsp_valid.
REQ-013 rsp_err  out  1  timeout flag, valid with rsp_valid.
REQ-014 psel, penable, pwrite  out  1 each  APB control to slave.
REQ-015 paddr  out  ADDR_W; pwdata  out  DATA_W  APB address/write data.
REQ-016 pready  in  1; prdata  in  DATA_W  APB slave response.

Function
REQ-017 The FSM SHALL have states IDLE, SETUP and ACCESS; all outputs SHALL be registered.
REQ-018 cmd_ready SHALL be 1 only in IDLE; a command is accepted on a rising edge where cmd_valid=1 and cmd_ready=1.
REQ-019 On acceptance, the FSM SHALL move IDLE->SETUP and latch cmd_write/cmd_addr/cmd_wdata into pwrite/paddr/pwdata.
REQ-020 SETUP SHALL drive psel=1, penable=0 for exactly one cycle, then move to ACCESS.
REQ-021 ACCESS SHALL drive psel=1, penable=1 and remain there while pready=0.
REQ-022 paddr, pwrite and pwdata SHALL hold stable from SETUP through the end of ACCESS.
REQ-023 On the edge where pready=1 is sampled in ACCESS, the block SHALL pulse rsp_valid=1 with rsp_err=0, drop psel/penable to 0 and return to IDLE.
REQ-024 rsp_rdata SHALL capture prdata on that edge for reads, and SHALL be 0 for writes.
REQ-025 rsp_valid SHALL be high for exactly one cycle per transfer.
REQ-026 Minimum transfer latency SHALL be 3 cycles from acceptance to rsp_valid (pready high in first ACCESS cycle); the next command SHALL be accepted in the rsp_valid cycle at earliest.
REQ-027 pready in IDLE or SETUP SHALL be ignored.
REQ-028 cmd_* changes while not in IDLE SHALL have no effect.

Reset
REQ-029 With presetn=0 at a rising edge, the FSM SHALL enter IDLE and drive psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata and rsp_err to 0; cmd_ready SHALL be 1 on the first cycle after reset releases.
REQ-030 Reset in SETUP or ACCESS SHALL abandon the transfer with no rsp_valid pulse.

Configuration
REQ-031 With macro APB_MASTER_TIMEOUT_EN defined, a counter SHALL count ACCESS cycles with pready=0, and clear on entering SETUP.
REQ-032 With APB_MASTER_TIMEOUT_EN defined, once TIMEOUT_CYCLES consecutive ACCESS cycles have pready=0, the block SHALL pulse rsp_valid=1, rsp_err=1, rsp_rdata=0 and return to IDLE.
REQ-033 With APB_MASTER_TIMEOUT_EN defined, pready=1 on the threshold edge SHALL take priority and complete normally with rsp_err=0.
REQ-034 With APB_MASTER_TIMEOUT_EN undefined, ACCESS SHALL wait indefinitely, no counter SHALL exist, and rsp_err SHALL be constant 0.

Verification
REQ-035 Write addr 0x05 data 0xA5, slave answers pready one cycle after ACCESS -> psel/penable sequence 10 then 11, rsp_valid 4 cycles after acceptance, rsp_err=0, slave mem[5]=0xA5.
REQ-036 Read addr 0x05 after REQ-035 write -> rsp_rdata=0xA5 with rsp_valid pulse, pwrite=0 throughout.
REQ-037 Back-to-back commands held on cmd_valid (write 0x01/0x11, then read 0x01) -> second accepted in rsp_valid cycle of first, read returns 0x11.
REQ-038 presetn=0 during ACCESS of a write -> next cycle psel=penable=0, cmd_ready=1, no rsp_valid.
REQ-039 With APB_MASTER_TIMEOUT_EN, pready tied 0 -> rsp_valid with rsp_err=1, rsp_rdata=0 after 16 ACCESS cycles; with the macro undefined, psel/penable held indefinitely.

Source files
------------

// File: rtl/apb_master.sv
// APB master bridge: accepts one command at a time on a valid/ready port,
// runs the APB SETUP/ACCESS handshake and returns a one-cycle completion
// pulse with read data.
// Optional build macro APB_MASTER_TIMEOUT_EN: bounds the ACCESS wait to
// TIMEOUT_CYCLES consecutive pready=0 cycles and reports rsp_err=1 on expiry.
// Without the macro, ACCESS waits indefinitely and rsp_err is tied to 0.
module apb_master #(
    parameter int ADDR_W         = 8,
    parameter int DATA_W         = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              pclk,
    input  logic              presetn,
    // command port
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    // response port
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    // APB side
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic              pready,
    input  logic [DATA_W-1:0] prdata
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;

    logic                r_cmd_ready,   w_cmd_ready_next;
    logic                r_psel,        w_psel_next;
    logic                r_penable,     w_penable_next;
    logic                r_pwrite,      w_pwrite_next;
    logic [ADDR_W-1:0]   r_paddr,       w_paddr_next;
    logic [DATA_W-1:0]   r_pwdata,      w_pwdata_next;
    logic                r_rsp_valid,   w_rsp_valid_next;
    logic [DATA_W-1:0]   r_rsp_rdata,   w_rsp_rdata_next;

    // A non-positive wait limit has no sensible meaning; nothing is built
    // for it, the check simply documents the legal range.
    if (TIMEOUT_CYCLES < 1) begin : g_timeout_range_invalid
    end

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic                r_rsp_err,     w_rsp_err_next;
    logic [CNT_W-1:0]    r_wait_cnt,    w_wait_cnt_next;
    logic                w_timeout;

    // This ACCESS cycle is the TIMEOUT_CYCLES-th one with pready low.
    assign w_timeout = (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

    // Next-state and next-output logic; every registered output is computed here.
    always_comb begin
        w_state_next     = r_state;
        w_psel_next      = r_psel;
        w_penable_next   = r_penable;
        w_pwrite_next    = r_pwrite;
        w_paddr_next     = r_paddr;
        w_pwdata_next    = r_pwdata;
        w_rsp_valid_next = 1'b0;
        w_rsp_rdata_next = r_rsp_rdata;
`ifdef APB_MASTER_TIMEOUT_EN
        w_rsp_err_next   = r_rsp_err;
        w_wait_cnt_next  = r_wait_cnt;
`endif
        case (r_state)
            ST_IDLE: begin
                if (cmd_valid && r_cmd_ready) begin
                    w_state_next   = ST_SETUP;
                    w_psel_next    = 1'b1;
                    w_penable_next = 1'b0;
                    w_pwrite_next  = cmd_write;
                    w_paddr_next   = cmd_addr;
                    w_pwdata_next  = cmd_wdata;
`ifdef APB_MASTER_TIMEOUT_EN
                    w_wait_cnt_next = '0;
`endif
                end
            end
            ST_SETUP: begin
                // pready is not looked at here: SETUP always lasts one cycle.
                w_state_next   = ST_ACCESS;
                w_penable_next = 1'b1;
            end
            ST_ACCESS: begin
                // pready wins over an expiring timeout on the same edge.
                if (pready) begin
                    w_state_next     = ST_IDLE;
                    w_psel_next      = 1'b0;
                    w_penable_next   = 1'b0;
                    w_rsp_valid_next = 1'b1;
                    w_rsp_rdata_next = r_pwrite ? '0 : prdata;
`ifdef APB_MASTER_TIMEOUT_EN
                    w_rsp_err_next   = 1'b0;
`endif
                end
`ifdef APB_MASTER_TIMEOUT_EN
                else if (w_timeout) begin
                    w_state_next     = ST_IDLE;
                    w_psel_next      = 1'b0;
                    w_penable_next   = 1'b0;
                    w_rsp_valid_next = 1'b1;
                    w_rsp_rdata_next = '0;
                    w_rsp_err_next   = 1'b1;
                end else begin
                    w_wait_cnt_next  = r_wait_cnt + CNT_W'(1);
                end
`endif
            end
            default: begin
                w_state_next   = ST_IDLE;
                w_psel_next    = 1'b0;
                w_penable_next = 1'b0;
            end
        endcase
        // Ready is registered, so it is derived from where the FSM is going.
        w_cmd_ready_next = (w_state_next == ST_IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            r_state     <= ST_IDLE;
            r_cmd_ready <= 1'b1;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_state     <= w_state_next;
            r_cmd_ready <= w_cmd_ready_next;
            r_psel      <= w_psel_next;
            r_penable   <= w_penable_next;
            r_pwrite    <= w_pwrite_next;
            r_paddr     <= w_paddr_next;
            r_pwdata    <= w_pwdata_next;
            r_rsp_valid <= w_rsp_valid_next;
            r_rsp_rdata <= w_rsp_rdata_next;
        end
    end

`ifdef APB_MASTER_TIMEOUT_EN
    // Wait-cycle counter and error flag for the ACCESS timeout.
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            r_wait_cnt <= '0;
            r_rsp_err  <= 1'b0;
        end else begin
            r_wait_cnt <= w_wait_cnt_next;
            r_rsp_err  <= w_rsp_err_next;
        end
    end

    assign rsp_err = r_rsp_err;
`else
    assign rsp_err = 1'b0;
`endif

    assign cmd_ready = r_cmd_ready;
    assign psel      = r_psel;
    assign penable   = r_penable;
    assign pwrite    = r_pwrite;
    assign paddr     = r_paddr;
    assign pwdata    = r_pwdata;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master: randomized commands, an APB slave
// model with scripted wait states, and a response scoreboard.
// Build with +define+APB_MASTER_TIMEOUT_EN to check the timeout variant.
module tb_apb_master;

    localparam int AW  = 8;
    localparam int DW  = 8;
    localparam int TMO = 16;

    logic          pclk = 1'b0;
    logic          presetn = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          psel, penable, pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic          pready = 1'b0;
    logic [DW-1:0] prdata = '0;

    apb_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TMO)) dut (
        .pclk(pclk), .presetn(presetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pready(pready), .prdata(prdata)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        bit            w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [DW-1:0] rdata;
        bit            err;
        int            due;
    } exp_t;

    exp_t          rsp_q[$];
    int            wq[$];
    logic [DW-1:0] model_mem [256];
    logic [DW-1:0] slave_mem [256];
    int            cyc = 0;
    int            n_tests = 0;
    int            n_fail = 0;
    int            last_acc = 0;
    int            last_rsp_cyc = 0;
    int            n_rsp = 0;

    always @(posedge pclk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endfunction

    // Reference rules: a transfer takes 3 cycles plus slave wait states;
    // with the timeout build, TMO idle ACCESS cycles end it with an error.
    function automatic bit times_out(input int waits);
`ifdef APB_MASTER_TIMEOUT_EN
        return waits >= TMO;
`else
        return 1'b0;
`endif
    endfunction

    function automatic int exp_latency(input int waits);
        if (times_out(waits)) return 2 + TMO;
        return 3 + waits;
    endfunction

    // Present a command (called at a negedge) and hold it until accepted.
    task automatic send(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d, input int waits);
        bit   rdy;
        int   acc;
        exp_t e;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        for (int t = 0; t < 300; t++) begin
            rdy = cmd_ready;
            acc = cyc;
            @(posedge pclk);
            if (rdy) begin
                e.w     = w;
                e.a     = a;
                e.d     = d;
                e.err   = times_out(waits);
                e.rdata = (w || e.err) ? '0 : model_mem[a];
                e.due   = acc + exp_latency(waits);
                wq.push_back(waits);
                rsp_q.push_back(e);
                last_acc = acc;
                @(negedge pclk);
                return;
            end
            @(negedge pclk);
        end
        n_tests++;
        n_fail++;
        $display("FAIL accept_timeout: command never accepted, required acceptance within 300 cycles");
    endtask

    // Drop cmd_valid and scramble the other command inputs.
    task automatic idle();
        cmd_valid = 1'b0;
        cmd_write = 1'($urandom);
        cmd_addr  = AW'($urandom);
        cmd_wdata = DW'($urandom);
    endtask

    task automatic drain(input int budget);
        for (int t = 0; t < budget && rsp_q.size() != 0; t++) @(negedge pclk);
        n_tests++;
        if (rsp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d responses outstanding, required 0", rsp_q.size());
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_psel"},      psel,      1'b0);
        check({tag, "_penable"},   penable,   1'b0);
        check({tag, "_pwrite"},    pwrite,    1'b0);
        check({tag, "_paddr"},     paddr,     '0);
        check({tag, "_pwdata"},    pwdata,    '0);
        check({tag, "_rsp_valid"}, rsp_valid, 1'b0);
        check({tag, "_rsp_rdata"}, rsp_rdata, '0);
        check({tag, "_rsp_err"},   rsp_err,   1'b0);
        check({tag, "_cmd_ready"}, cmd_ready, 1'b1);
    endtask

    // Response monitor: pops the scoreboard whenever rsp_valid is seen.
    always @(negedge pclk) begin
        exp_t e;
        if (presetn) begin
            if (rsp_valid) begin
                if (rsp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL spurious_rsp: rsp_valid=1 with no transfer outstanding");
                end else begin
                    e = rsp_q.pop_front();
                    n_rsp++;
                    check("rsp_rdata",   rsp_rdata, e.rdata);
                    check("rsp_err",     rsp_err,   e.err);
                    check("rsp_latency", cyc,       e.due);
                    if (e.w && !e.err) model_mem[e.a] = e.d;
                    last_rsp_cyc = cyc;
                    $display("[TB] rsp %0d: %s addr=0x%02h wdata=0x%02h rdata=0x%02h err=%0d cycle=%0d",
                             n_rsp, e.w ? "WR" : "RD", e.a, e.d, rsp_rdata, rsp_err, cyc);
                end
            end else if (rsp_q.size() != 0 && cyc >= rsp_q[0].due) begin
                e = rsp_q.pop_front();
                n_tests++;
                n_fail++;
                $display("FAIL missing_rsp: no rsp_valid at cycle %0d, required one for addr 0x%02h", cyc, e.a);
            end
            check("cmd_ready", cmd_ready, rsp_q.size() == 0);
        end
    end

    // APB slave model: scripted wait states, memory, and protocol checks.
    int s_wait = 0;
    int s_cnt  = 0;
    bit prev_psel = 1'b0;
    bit prev_setup = 1'b0;

    always @(negedge pclk) begin
        prdata = DW'($urandom);
        if (!presetn) begin
            pready     = 1'b0;
            prev_psel  = 1'b0;
            prev_setup = 1'b0;
        end else if (psel && !penable) begin
            check("setup_one_cycle", prev_setup, 1'b0);
            if (rsp_q.size() != 0) begin
                check("setup_paddr",  paddr,  rsp_q[0].a);
                check("setup_pwrite", pwrite, rsp_q[0].w);
                check("setup_pwdata", pwdata, rsp_q[0].d);
            end
            s_wait     = (wq.size() != 0) ? wq.pop_front() : 0;
            s_cnt      = 0;
            pready     = 1'($urandom);
            prev_setup = 1'b1;
            prev_psel  = 1'b1;
        end else if (psel && penable) begin
            check("access_follows_psel", prev_psel, 1'b1);
            if (rsp_q.size() != 0) begin
                check("access_paddr",  paddr,  rsp_q[0].a);
                check("access_pwrite", pwrite, rsp_q[0].w);
                check("access_pwdata", pwdata, rsp_q[0].d);
            end
            pready = (s_cnt == s_wait);
            if (pready) begin
                if (pwrite) slave_mem[paddr] = pwdata;
                else        prdata = slave_mem[paddr];
            end
            s_cnt++;
            prev_setup = 1'b0;
            prev_psel  = 1'b1;
        end else begin
            if (penable) check("penable_without_psel", penable, 1'b0);
            pready     = 1'($urandom);
            prev_setup = 1'b0;
            prev_psel  = 1'b0;
        end
    end

    initial begin
        int acc1;
        for (int i = 0; i < 256; i++) begin
            model_mem[i] = DW'(i) ^ 8'h5A;
            slave_mem[i] = DW'(i) ^ 8'h5A;
        end

        // Power-on reset.
        presetn = 1'b0;
        repeat (3) @(posedge pclk);
        @(negedge pclk);
        check_reset_outputs("por");
        presetn = 1'b1;

        // Write 0x05/0xA5 with one wait state, then read it back.
        send(1'b1, 8'h05, 8'hA5, 1);
        idle();
        drain(50);
        check("slave_mem5", slave_mem[5], 8'hA5);
        send(1'b0, 8'h05, 8'h3C, 0);
        idle();
        drain(50);

        // Back-to-back with cmd_valid held: second accepted in first's rsp cycle.
        send(1'b1, 8'h01, 8'h11, 0);
        acc1 = last_acc;
        send(1'b0, 8'h01, 8'hE7, 0);
        check("b2b_accept_cycle", last_acc, acc1 + 3);
        idle();
        drain(50);

        // Wait just below the timeout threshold, then a long stall.
        send(1'b1, 8'h20, 8'h77, TMO - 1);
        idle();
        drain(100);
        send(1'b0, 8'h20, 8'h00, 0);
        idle();
        drain(50);
        send(1'b1, 8'h30, 8'h99, 40);
        idle();
        drain(100);
        send(1'b0, 8'h30, 8'h00, 2);
        idle();
        drain(50);

        // Reset while a write sits in ACCESS: transfer is abandoned.
        send(1'b1, 8'h40, 8'hCC, 10);
        idle();
        @(negedge pclk);
        check("in_access_psel",    psel,    1'b1);
        check("in_access_penable", penable, 1'b1);
        presetn = 1'b0;
        @(posedge pclk);
        rsp_q.delete();
        wq.delete();
        @(negedge pclk);
        check_reset_outputs("rst_access");
        presetn = 1'b1;
        check("rst_slave_mem40", slave_mem[8'h40], model_mem[8'h40]);
        send(1'b0, 8'h40, 8'h00, 0);
        idle();
        drain(50);

        // Randomized traffic over a small address window.
        for (int n = 0; n < 60; n++) begin
            send(1'($urandom), AW'($urandom_range(0, 15)), DW'($urandom), $urandom_range(0, 4));
            if ($urandom_range(0, 2) != 0) begin
                idle();
                repeat ($urandom_range(0, 2)) @(negedge pclk);
            end
        end
        idle();
        drain(100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
